mem_access_seq: RTL and testbench

// - Memory access sequencer directly downstream of the LC-3 control unit (ISDU).
// - Converts the control unit's active-low Mem_CE/OE/WE/UB/LB strobes, the MAR address and MDR write data into timed async-SRAM cycles.
// - Runs a programmable number of wait states per access, registers read data for the MDR and reports completion with a Mem_Rdy pulse.

---
 rtl/mem_seq_pkg.sv | 26 ++
 rtl/mem_access_seq_wait_cnt.sv | 39 +++
 rtl/mem_access_seq.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the LC-3 memory access sequencer.
package mem_seq_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ACT   = 3'd1,
        RD_CAP   = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        DONE     = 3'd6
    } state_e;

    // True in states where the SRAM read strobes are active.
    function automatic logic is_rd_state(input state_e s);
        return (s == RD_ACT) || (s == RD_CAP);
    endfunction

    // True in states where the write data is driven onto DQ.
    function automatic logic is_wr_state(input state_e s);
        return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
    endfunction

endpackage

// File: rtl/mem_access_seq_wait_cnt.sv
// Load / decrement / zero-flag wait-state counter shared by read and write paths.
module mem_wait_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mem_access_seq.sv
// Turns LC-3 control-unit memory strobes into timed async-SRAM cycles.
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Mem_CE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] Addr_in,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Mem_Rdy,
    output logic              Proto_err,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);

    state_e              state_q, state_d;
    logic                armed_q, armed_d;
    logic                perr_q, perr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ub_lat_q, ub_lat_d;
    logic                lb_lat_q, lb_lat_d;
    logic                rdy_q, rdy_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                ub_n_q, ub_n_d;
    logic                lb_n_q, lb_n_d;
    logic                dq_oe_q, dq_oe_d;

    logic                  start_c;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic [WAIT_CNT_W-1:0] cnt_load_val;
    logic [WAIT_CNT_W-1:0] cnt_val;
    logic                  cnt_zero_c;

    mem_wait_cnt #(
        .W(WAIT_CNT_W)
    ) u_wait_cnt (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .zero_c     (cnt_zero_c)
    );

    // Next-state, request latching, arming and registered-output decode.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        perr_d       = perr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        ub_lat_d     = ub_lat_q;
        lb_lat_d     = lb_lat_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = WAIT_CNT_W'(READ_WAIT);

        start_c = (state_q == IDLE) && armed_q && !Mem_CE && (!Mem_WE || !Mem_OE);

        unique case (state_q)
            IDLE: begin
                if (start_c) begin
                    addr_d   = Addr_in;
                    wdata_d  = Data_from_CPU;
                    ub_lat_d = Mem_UB;
                    lb_lat_d = Mem_LB;
                    if (!Mem_WE) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d      = RD_ACT;
                        cnt_load     = 1'b1;
                        cnt_load_val = WAIT_CNT_W'(READ_WAIT);
                    end
                end
            end
            RD_ACT: begin
                if (cnt_zero_c) begin
                    state_d = RD_CAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_CAP: begin
                rdata_d = SRAM_DQ;
                state_d = DONE;
            end
            WR_SETUP: begin
                state_d      = WR_PULSE;
                cnt_load     = 1'b1;
                cnt_load_val = WAIT_CNT_W'(WRITE_WAIT);
            end
            WR_PULSE: begin
                if (cnt_zero_c) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A strobe held low past completion must not retrigger an access.
        if (start_c) begin
            armed_d = 1'b0;
        end
        if (Mem_OE && Mem_WE) begin
            armed_d = 1'b1;
        end
        if (!Mem_OE && !Mem_WE) begin
            perr_d = 1'b1;
        end

        // SRAM controls follow the next state so they come straight from flops.
        ce_n_d  = !(is_rd_state(state_d) || is_wr_state(state_d));
        oe_n_d  = !is_rd_state(state_d);
        we_n_d  = (state_d != WR_PULSE);
        dq_oe_d = is_wr_state(state_d);
        ub_n_d  = ce_n_d ? 1'b1 : ub_lat_d;
        lb_n_d  = ce_n_d ? 1'b1 : lb_lat_d;
        rdy_d   = (state_d == DONE);
    end

    // State and output registers; reset forces the bus idle immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            armed_q  <= 1'b1;
            perr_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ub_lat_q <= 1'b1;
            lb_lat_q <= 1'b1;
            rdy_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            perr_q   <= perr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ub_lat_q <= ub_lat_d;
            lb_lat_q <= lb_lat_d;
            rdy_q    <= rdy_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
            dq_oe_q  <= dq_oe_d;
        end
    end

    assign Data_to_CPU = rdata_q;
    assign Mem_Rdy     = rdy_q;
    assign Proto_err   = perr_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_UB_N   = ub_n_q;
    assign SRAM_LB_N   = lb_n_q;
    assign SRAM_DQ     = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: cycle model plus directed literal checks.
module tb_mem_access_seq;

    localparam int unsigned RW = 1;
    localparam int unsigned WW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ---------------- DUT A: READ_WAIT=1, WRITE_WAIT=2 ----------------
    logic        a_ce = 1'b1, a_oe = 1'b1, a_we = 1'b1, a_ub = 1'b0, a_lb = 1'b0;
    logic [19:0] a_addr = '0;
    logic [15:0] a_wdata = '0;
    logic [15:0] a_rdata;
    logic        a_rdy, a_perr, a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;
    logic [19:0] a_sram_addr;
    wire  [15:0] sram_dq_a;

    mem_access_seq #(.ADDR_W(20), .DATA_W(16), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut_a (
        .Clk(clk), .Reset_n(rst_n),
        .Mem_CE(a_ce), .Mem_UB(a_ub), .Mem_LB(a_lb), .Mem_OE(a_oe), .Mem_WE(a_we),
        .Addr_in(a_addr), .Data_from_CPU(a_wdata), .Data_to_CPU(a_rdata),
        .Mem_Rdy(a_rdy), .Proto_err(a_perr), .SRAM_ADDR(a_sram_addr),
        .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n), .SRAM_WE_N(a_we_n),
        .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n), .SRAM_DQ(sram_dq_a)
    );

    // ---------------- DUT B: READ_WAIT=0, WRITE_WAIT=0 ----------------
    logic        b_ce = 1'b1, b_oe = 1'b1, b_we = 1'b1;
    logic [19:0] b_addr = '0;
    logic [15:0] b_rdata;
    logic        b_rdy, b_perr, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;
    logic [19:0] b_sram_addr;
    wire  [15:0] sram_dq_b;

    mem_access_seq #(.ADDR_W(20), .DATA_W(16), .READ_WAIT(0), .WRITE_WAIT(0)) dut_b (
        .Clk(clk), .Reset_n(rst_n),
        .Mem_CE(b_ce), .Mem_UB(1'b0), .Mem_LB(1'b0), .Mem_OE(b_oe), .Mem_WE(b_we),
        .Addr_in(b_addr), .Data_from_CPU(16'h0000), .Data_to_CPU(b_rdata),
        .Mem_Rdy(b_rdy), .Proto_err(b_perr), .SRAM_ADDR(b_sram_addr),
        .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n),
        .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n), .SRAM_DQ(sram_dq_b)
    );

    // Power-up contents of the emulated SRAMs.
    function automatic logic [15:0] init_a(input logic [9:0] a);
        return (a == 10'h123) ? 16'hBEEF : 16'h0000;
    endfunction
    function automatic logic [15:0] init_b(input logic [9:0] a);
        return (a == 10'h005) ? 16'hA5A5 : 16'h0000;
    endfunction

    // Async SRAM devices: drive DQ on read, store on WE low.
    logic [15:0] mem_a [1024];
    bit          wr_a  [1024];
    logic [15:0] mem_b [1024];
    bit          wr_b  [1024];

    assign sram_dq_a = (!a_ce_n && !a_oe_n && a_we_n)
                     ? (wr_a[a_sram_addr[9:0]] ? mem_a[a_sram_addr[9:0]] : init_a(a_sram_addr[9:0]))
                     : 16'hzzzz;
    assign sram_dq_b = (!b_ce_n && !b_oe_n && b_we_n)
                     ? (wr_b[b_sram_addr[9:0]] ? mem_b[b_sram_addr[9:0]] : init_b(b_sram_addr[9:0]))
                     : 16'hzzzz;

    always @(posedge clk) begin
        if (!a_ce_n && !a_we_n) begin
            mem_a[a_sram_addr[9:0]] <= sram_dq_a;
            wr_a[a_sram_addr[9:0]]  <= 1'b1;
        end
        if (!b_ce_n && !b_we_n) begin
            mem_b[b_sram_addr[9:0]] <= sram_dq_b;
            wr_b[b_sram_addr[9:0]]  <= 1'b1;
        end
    end

    function automatic logic [15:0] dev_a_word(input logic [9:0] a);
        return wr_a[a] ? mem_a[a] : init_a(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- Transaction-level model of DUT A ----------------
    // busy/k: k counts cycles since the request was sampled (request cycle = 0).
    logic        m_busy, m_is_wr, m_armed, m_perr, m_ub, m_lb;
    int          m_k;
    logic [19:0] m_addr;
    logic [15:0] m_wdata, m_data;
    logic [15:0] m_mem [1024];
    bit          m_wr  [1024];

    function automatic int m_last(input logic is_wr);
        return is_wr ? int'(WW) + 4 : int'(RW) + 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_is_wr <= 1'b0;
            m_armed <= 1'b1;
            m_perr  <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_data  <= '0;
            m_ub    <= 1'b1;
            m_lb    <= 1'b1;
        end else begin
            if (!a_oe && !a_we) m_perr <= 1'b1;
            if (!m_busy && m_armed && !a_ce && (!a_oe || !a_we)) begin
                m_busy  <= 1'b1;
                m_k     <= 1;
                m_is_wr <= !a_we;
                m_addr  <= a_addr;
                m_wdata <= a_wdata;
                m_ub    <= a_ub;
                m_lb    <= a_lb;
                m_armed <= 1'b0;
            end else if (m_busy) begin
                if (m_k == m_last(m_is_wr)) begin
                    m_busy <= 1'b0;
                    if (m_is_wr) begin
                        m_mem[m_addr[9:0]] <= m_wdata;
                        m_wr[m_addr[9:0]]  <= 1'b1;
                    end
                end else begin
                    m_k <= m_k + 1;
                end
                if (!m_is_wr && m_k == int'(RW) + 2)
                    m_data <= m_wr[m_addr[9:0]] ? m_mem[m_addr[9:0]] : init_a(m_addr[9:0]);
            end
            if (a_oe && a_we) m_armed <= 1'b1;
        end
    end

    // Per-cycle comparison of DUT A against the model.
    always @(posedge clk) begin
        logic rd_act, wr_act, e_we_n, e_rdy;
        #1;
        if (rst_n) begin
            rd_act = m_busy && !m_is_wr && m_k >= 1 && m_k <= int'(RW) + 2;
            wr_act = m_busy &&  m_is_wr && m_k >= 1 && m_k <= int'(WW) + 3;
            e_we_n = !(m_busy && m_is_wr && m_k >= 2 && m_k <= int'(WW) + 2);
            e_rdy  = m_busy && (m_k == m_last(m_is_wr));
            chk("cyc_ce_n", 32'(a_ce_n), 32'(!(rd_act || wr_act)));
            chk("cyc_oe_n", 32'(a_oe_n), 32'(!rd_act));
            chk("cyc_we_n", 32'(a_we_n), 32'(e_we_n));
            chk("cyc_ub_n", 32'(a_ub_n), 32'((rd_act || wr_act) ? m_ub : 1'b1));
            chk("cyc_lb_n", 32'(a_lb_n), 32'((rd_act || wr_act) ? m_lb : 1'b1));
            chk("cyc_rdy",  32'(a_rdy),  32'(e_rdy));
            chk("cyc_perr", 32'(a_perr), 32'(m_perr));
            chk("cyc_addr", 32'(a_sram_addr), 32'(m_addr));
            chk("cyc_rdata", 32'(a_rdata), 32'(m_data));
            if (wr_act) chk("cyc_dq", 32'(sram_dq_a), 32'(m_wdata));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int rdy_cnt;
        int rdy_total;

        // Reset state
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_ce_n", 32'(a_ce_n), 32'd1);
        chk("rst_oe_n", 32'(a_oe_n), 32'd1);
        chk("rst_we_n", 32'(a_we_n), 32'd1);
        chk("rst_ub_lb_n", 32'({a_ub_n, a_lb_n}), 32'd3);
        chk("rst_addr", 32'(a_sram_addr), 32'd0);
        chk("rst_rdata", 32'(a_rdata), 32'd0);
        chk("rst_rdy_perr", 32'({a_rdy, a_perr}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Read 0x00123, READ_WAIT=1: OE_N low cycles 1..3, Rdy and data at cycle 4
        a_addr = 20'h00123; a_ce = 1'b0; a_oe = 1'b0;
        tick(); a_ce = 1'b1; a_oe = 1'b1;
        chk("rd_c1_oe_n", 32'(a_oe_n), 32'd0);
        chk("rd_c1_addr", 32'(a_sram_addr), 32'h00123);
        tick(); chk("rd_c2_oe_n", 32'(a_oe_n), 32'd0);
        tick(); chk("rd_c3_oe_n", 32'(a_oe_n), 32'd0);
        chk("rd_c3_rdy", 32'(a_rdy), 32'd0);
        tick(); chk("rd_c4_rdy", 32'(a_rdy), 32'd1);
        chk("rd_c4_oe_n", 32'(a_oe_n), 32'd1);
        chk("rd_c4_data", 32'(a_rdata), 32'h0000BEEF);
        tick(); chk("rd_c5_rdy", 32'(a_rdy), 32'd0);

        // Write 0x1234 to 0x00040, WRITE_WAIT=2
        a_addr = 20'h00040; a_wdata = 16'h1234; a_ce = 1'b0; a_we = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin a_ce = 1'b1; a_we = 1'b1; end
            chk("wr_we_n", 32'(a_we_n), 32'((c >= 2 && c <= 4) ? 1'b0 : 1'b1));
            chk("wr_rdy", 32'(a_rdy), 32'((c == 6) ? 1'b1 : 1'b0));
            if (c <= 5) chk("wr_dq", 32'(sram_dq_a), 32'h1234);
        end
        tick();
        chk("wr_mem", 32'(dev_a_word(10'h040)), 32'h1234);
        chk("wr_rdata_kept", 32'(a_rdata), 32'h0000BEEF);

        // OE held low 10 cycles: one access only; release + reassert gives a second
        rdy_cnt = 0; rdy_total = 0;
        a_addr = 20'h00040; a_ce = 1'b0; a_oe = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_rdy) rdy_cnt++;
        end
        chk("hold_one_rdy", 32'(rdy_cnt), 32'd1);
        chk("hold_data", 32'(a_rdata), 32'h1234);
        a_ce = 1'b1; a_oe = 1'b1;
        tick(); tick();
        a_addr = 20'h00123; a_ce = 1'b0; a_oe = 1'b0;
        tick(); a_ce = 1'b1; a_oe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (a_rdy) rdy_total++;
            tick();
        end
        chk("rearm_rdy", 32'(rdy_total), 32'd1);
        chk("rearm_data", 32'(a_rdata), 32'h0000BEEF);

        // OE and WE both low: write wins, Proto_err sticky
        chk("perr_pre", 32'(a_perr), 32'd0);
        a_addr = 20'h00050; a_wdata = 16'h5555; a_ub = 1'b1; a_ce = 1'b0; a_oe = 1'b0; a_we = 1'b0;
        tick(); a_ce = 1'b1; a_oe = 1'b1; a_we = 1'b1; a_ub = 1'b0;
        chk("both_perr", 32'(a_perr), 32'd1);
        chk("both_ub_n", 32'(a_ub_n), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("both_mem", 32'(dev_a_word(10'h050)), 32'h5555);
        chk("both_perr_sticky", 32'(a_perr), 32'd1);
        chk("both_rdata_kept", 32'(a_rdata), 32'h0000BEEF);

        // Reset asserted during WR_PULSE takes effect at once
        a_addr = 20'h00060; a_wdata = 16'h0F0F; a_ce = 1'b0; a_we = 1'b0;
        tick(); a_ce = 1'b1; a_we = 1'b1;
        tick();
        chk("rstmid_in_pulse", 32'(a_we_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_we_n", 32'(a_we_n), 32'd1);
        chk("rstmid_ce_n", 32'(a_ce_n), 32'd1);
        chk("rstmid_rdy", 32'(a_rdy), 32'd0);
        chk("rstmid_perr", 32'(a_perr), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("rstmid_idle_ce_n", 32'(a_ce_n), 32'd1);
        chk("rstmid_no_write", 32'(dev_a_word(10'h060)), 32'h0000);

        // Read after reset
        a_addr = 20'h00040; a_ce = 1'b0; a_oe = 1'b0;
        tick(); a_ce = 1'b1; a_oe = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_data", 32'(a_rdata), 32'h1234);

        // DUT B, READ_WAIT=0: Rdy at cycle 3
        b_addr = 20'h00005; b_ce = 1'b0; b_oe = 1'b0;
        tick(); b_ce = 1'b1; b_oe = 1'b1;
        chk("b_c1_strobes", 32'({b_ce_n, b_oe_n, b_rdy}), 32'd0);
        tick(); chk("b_c2_strobes", 32'({b_ce_n, b_oe_n, b_rdy}), 32'd0);
        tick(); chk("b_c3_rdy", 32'(b_rdy), 32'd1);
        chk("b_c3_oe_n", 32'(b_oe_n), 32'd1);
        chk("b_c3_data", 32'(b_rdata), 32'h0000A5A5);
        tick(); chk("b_c4_rdy", 32'(b_rdy), 32'd0);

        // DUT B: Mem_CE=1 blocks a start
        b_ce = 1'b1; b_oe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b_noce_ce_n", 32'(b_ce_n), 32'd1);
            chk("b_noce_rdy", 32'(b_rdy), 32'd0);
        end
        b_oe = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
